// File: rtl/turn_pkg.sv
// turn_pkg: state codes, state type and lamp sequence map shared by the turn-signal controller
package turn_pkg;
   typedef logic [2:0] state_t;
   localparam state_t IDEL   = 3'b000;
   localparam state_t LEFT   = 3'b001;
   localparam state_t RIGHT  = 3'b010;
   localparam state_t LBREAK = 3'b011;
   localparam state_t RBREAK = 3'b100;
   localparam state_t BREAK  = 3'b101;
   localparam state_t HAZARD = 3'b110;
   function automatic logic [2:0] seq(input logic [1:0] n);
      return n == 2'd0 ? 3'b000 : n == 2'd1 ? 3'b001 : n == 2'd2 ? 3'b011 : 3'b111;
   endfunction
endpackage

// File: rtl/tail_light_driver_tick_gen.sv
// tick_gen: blink prescaler, one-cycle tick every TICK_DIV cycles, restartable
module tick_gen #(
   parameter int TICK_DIV = 12_500_000
) (
   input  logic CLOCK_50,
   input  logic resetn,
   input  logic restart,
   output logic tick
);
   localparam int W = $clog2(TICK_DIV);
   localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);
   logic [W-1:0] tick_cnt_q, tick_cnt_d;
   // wrap at LAST, restart wins over a coincident tick
   always_comb begin
      tick_cnt_d = (restart || tick_cnt_q == LAST) ? '0 : tick_cnt_q + 1'b1;
      tick = tick_cnt_q == LAST && !restart;
   end
   // prescaler register
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) tick_cnt_q <= '0;
      else tick_cnt_q <= tick_cnt_d;
   end
endmodule

// File: rtl/tail_light_driver.sv
// tail_light_driver: state register, sequence counters and registered lamp decode
module tail_light_driver
   import turn_pkg::*;
#(
   parameter int TICK_DIV = 12_500_000
) (
   input  logic       CLOCK_50,
   input  logic       resetn,
   input  logic [2:0] next_state,
   input  logic       reset_count_lb,
   input  logic       reset_count_rb,
   input  logic       reset_count_h,
   output logic [2:0] current_state,
   output logic [9:0] LEDR
);
   state_t     state_q, state_d;
   logic [1:0] lb_q, lb_d, rb_q, rb_d;
   logic       h_q, h_d;
   logic [9:0] led_q, led_d;
   logic [2:0] left, right;
   logic       restart, tick;

   tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .CLOCK_50(CLOCK_50),
      .resetn  (resetn),
      .restart (restart),
      .tick    (tick)
   );

   // next state, counter steps (clear beats tick) and lamp pattern from current registers
   always_comb begin
      state_d = next_state == 3'b111 ? IDEL : next_state;
      restart = state_d != state_q;
      lb_d = reset_count_lb ? 2'd0 : lb_q + {1'b0, tick};
      rb_d = reset_count_rb ? 2'd0 : rb_q + {1'b0, tick};
      h_d = reset_count_h ? 1'b1 : h_q ^ tick;
      left = 3'b000;
      right = 3'b000;
      case (state_q)
         LEFT:    left = seq(lb_q);
         RIGHT:   right = seq(rb_q);
         LBREAK:  begin left = seq(lb_q); right = 3'b111; end
         RBREAK:  begin left = 3'b111; right = seq(rb_q); end
         BREAK:   begin left = 3'b111; right = 3'b111; end
         HAZARD:  begin left = {3{h_q}}; right = {3{h_q}}; end
         default: ;
      endcase
      led_d = {left, 4'b0000, right[0], right[1], right[2]};
   end

   // state, counter and lamp registers
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDEL;
         lb_q <= 2'd0;
         rb_q <= 2'd0;
         h_q <= 1'b1;
         led_q <= '0;
      end else begin
         state_q <= state_d;
         lb_q <= lb_d;
         rb_q <= rb_d;
         h_q <= h_d;
         led_q <= led_d;
      end
   end

   assign current_state = state_q;
   assign LEDR = led_q;
endmodule
